fetch_ctrl: RTL and testbench
=============================

# fetch_ctrl

Instruction-fetch sequencer for the 256-word instruction memory. It owns the program counter and issues one word address per cycle to the memory's registered read port. It tracks the single in-flight read, buffers returned words in a 2-entry skid buffer, and presents them to decode over a valid/ready handshake. It also supports redirect (branch/jump), start, and drain-to-stop.

## Interface
- WIDTH, 32, instruction width
- PC_W, 8, word-address width (memory depth 2^PC_W)
- RESET_PC, 0, PC value after reset
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- go  in  1  level; start/resume fetching when idle
- stop  in  1  level; stop issuing and drain
- redirect_valid  in  1  one-cycle pulse: load new PC, flush
- redirect_pc  in  PC_W  target word address
- imem_pc  out  PC_W  address to instruction memory
- imem_ins  in  WIDTH  memory read data; holds mem[A] in the cycle after imem_pc=A
- out_valid  out  1  buffered instruction available
- out_ins  out  WIDTH  instruction at buffer head
- out_pc  out  PC_W  address of out_ins
- out_ready  in  1  decode accepts head this cycle
- busy  out  1  state is not IDLE

## Operation
- States:
  - IDLE (reset state).
  - RUN.
  - DRAIN.
- State transitions:
  - IDLE→RUN when go=1 and stop=0.
  - RUN→DRAIN when stop=1.
  - DRAIN→IDLE when req_v=0 and buffer empty.
  - DRAIN→RUN is not allowed. Go is ignored outside IDLE.
- imem_pc is driven directly from the fetch_pc register in every state. Memory reads when no request is issued are harmless.
- Pop: pop = out_valid & out_ready.
- Issue:
  - Issue happens in RUN only when redirect_valid=0 and (cnt + req_v − pop) ≤ 1. Here cnt is the buffer occupancy (0..2).
  - On issue: req_v←1, req_pc←fetch_pc, fetch_pc←fetch_pc+1 (mod 2^PC_W; 255→0 wraps).
  - Without issue: req_v←0.
- Response: when req_v=1, {req_pc, imem_ins} is pushed into the buffer at the end of that cycle.
- Buffer overflow is impossible under the credit rule; the bench asserts it.
- Buffer: 2-entry FIFO. out_valid = (cnt≠0). out_ins and out_pc come from the head register. Push and pop in the same cycle are allowed at any occupancy.
- Redirect (any state):
  - fetch_pc←redirect_pc, req_v←0 (the in-flight word is discarded), buffer flushed, and no issue that cycle.
  - The head shown in the redirect cycle is still valid; a pop in that cycle counts as accepted.
  - The state is unchanged, except that DRAIN with redirect leads to IDLE on the next evaluation.
- Simultaneous events:
  - redirect+stop: both apply.
  - go+stop in IDLE: stay IDLE.
  - redirect+go in IDLE: PC loaded and RUN entered; the first issue happens at the new PC next cycle.
- Resume after IDLE continues from the retained fetch_pc.

## Timing
- Reset (async, immediate) sets the following:
  - state IDLE
  - fetch_pc and imem_pc = RESET_PC
  - req_v=0, cnt=0
  - out_valid=0, out_ins=0, out_pc=0
  - busy=0
- Reset mid-operation discards all in-flight and buffered words.
- Issue-to-out_valid latency is 2 cycles: address in cycle n, data in n+1, buffered and visible in n+2.
- go sampled in cycle n gives the first issue in n+1 and out_valid in n+3.
- redirect in cycle n gives imem_pc=target in n+1 and the target on out in n+3. out_valid is 0 in n+1 and n+2.
- Throughput is 1 instruction/cycle with out_ready held high.
- Stall: with out_ready=0, at most 2 words are buffered and imem_pc freezes. No word is lost or duplicated.
- Out-stability: while out_valid=1 and out_ready=0, out_ins and out_pc hold, unless a redirect flushes.

## Structure
- Package fetch_pkg holds the following:
  - the state enum {IDLE, RUN, DRAIN}
  - default PC_W, WIDTH, RESET_PC constants
- Sub-module fetch_skid_buf is a 2-entry FIFO:
  - parameterised on payload width PC_W+WIDTH
  - ports push, pop, flush, full/cnt, head
- fetch_ctrl holds the FSM, fetch_pc, the req_v/req_pc tracker, and the issue credit logic.

## Test plan
- Memory model mem[i]=32'h1000_0000+i. Reset, then go=1 at cycle 0, out_ready=1. Expected: imem_pc 0,1,2… from cycle 1. out_valid rises in cycle 3 with out_pc=0, out_ins=32'h1000_0000, then one word per cycle with consecutive pcs.
- Backpressure: in steady run, out_ready=0 for 5 cycles. Expected: cnt saturates at 2, imem_pc freezes, head holds. On release, out_pc continues with no gap or repeat.
- Redirect: redirect_valid with redirect_pc=8'h40 in cycle 10. Expected: imem_pc=8'h40 in cycle 11, out_valid=0 in cycles 11–12, out_pc=8'h40 and out_ins=32'h1000_0040 in cycle 13.
- Wrap: redirect to 8'hFE. Expected: out_pc sequence FE, FF, 00, 01 with matching data.
- Stop/resume: stop=1 mid-run with out_ready=1. Expected: no further issue, in-flight word delivered, busy=0 within 3 cycles. Then go resumes at the next unfetched pc.
- Async reset: rst_n low mid-run with a full buffer. Expected: out_valid, busy, out_ins and out_pc go to 0 and imem_pc goes to RESET_PC immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction-fetch sequencer.
package fetch_pkg;

  localparam int WIDTH_D    = 32;
  localparam int PC_W_D     = 8;
  localparam int RESET_PC_D = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } fetch_state_e;

  // A new read may start only if, counting the word already in flight and the
  // head leaving this cycle, at most one buffer slot is spoken for. The word
  // issued now lands two cycles later, so this keeps the 2-entry buffer from
  // ever overflowing.
  function automatic logic may_issue(input logic [1:0] cnt,
                                     input logic       req_v,
                                     input logic       pop);
    logic [2:0] used;
    used = {1'b0, cnt} + {2'b00, req_v} - {2'b00, pop};
    return (used <= 3'd1);
  endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// Two-entry FIFO holding {pc, instruction} words between memory and decode.
// Entry e0 is always the head, so the outputs come straight from a register.
module fetch_skid_buf #(
  parameter int DW = 40
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [DW-1:0] din,
  input  logic          pop,
  input  logic          flush,
  output logic          full,
  output logic [1:0]    cnt,
  output logic [DW-1:0] head
);

  logic [DW-1:0] e0;
  logic [DW-1:0] e1;
  logic [1:0]    cnt_q;

  // Occupancy and entry update; flush wins over push/pop, a push into a full
  // buffer without a pop is dropped (the credit rule upstream prevents it).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e0    <= '0;
      e1    <= '0;
      cnt_q <= 2'd0;
    end else if (flush) begin
      cnt_q <= 2'd0;
    end else begin
      case (cnt_q)
        2'd0: begin
          if (push) begin
            e0    <= din;
            cnt_q <= 2'd1;
          end
        end
        2'd1: begin
          case ({push, pop})
            2'b11: e0 <= din;
            2'b10: begin
              e1    <= din;
              cnt_q <= 2'd2;
            end
            2'b01: cnt_q <= 2'd0;
            default: ;
          endcase
        end
        2'd2: begin
          case ({push, pop})
            2'b11: begin
              e0 <= e1;
              e1 <= din;
            end
            2'b01: begin
              e0    <= e1;
              cnt_q <= 2'd1;
            end
            default: ;
          endcase
        end
        default: cnt_q <= 2'd0;
      endcase
    end
  end

  assign cnt  = cnt_q;
  assign full = (cnt_q == 2'd2);
  assign head = e0;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, issues one read per cycle to a
// registered-read memory, tracks the single in-flight read and hands words
// to decode through a 2-entry skid buffer.
//
// Decode handshake: a word transfers in a cycle where out_valid and out_ready
// are both 1; out_valid never depends on out_ready, and while out_valid=1 and
// out_ready=0 the head (out_ins/out_pc) holds unless a redirect flushes it.
module fetch_ctrl
  import fetch_pkg::*;
#(
  parameter int              WIDTH    = WIDTH_D,
  parameter int              PC_W     = PC_W_D,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(RESET_PC_D)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             go,
  input  logic             stop,
  input  logic             redirect_valid,
  input  logic [PC_W-1:0]  redirect_pc,
  output logic [PC_W-1:0]  imem_pc,
  input  logic [WIDTH-1:0] imem_ins,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_ins,
  output logic [PC_W-1:0]  out_pc,
  input  logic             out_ready,
  output logic             busy
);

  fetch_state_e    state;
  logic [PC_W-1:0] fetch_pc;
  logic            req_v;
  logic [PC_W-1:0] req_pc;

  logic [1:0]            cnt;
  logic                  buf_full;
  logic [PC_W+WIDTH-1:0] head;
  logic                  pop;
  logic                  push;
  logic                  hold;
  logic                  issue;

  assign pop  = out_valid & out_ready;
  // A redirect discards the word returning this cycle.
  assign push = req_v & ~redirect_valid;
  // Full with nothing leaving: never start a read.
  assign hold = buf_full & ~pop;
  // Stop takes effect immediately: no new read in the cycle it is seen.
  assign issue = (state == RUN) & ~stop & ~redirect_valid & ~hold &
                 may_issue(cnt, req_v, pop);

  // Control FSM; go is only looked at in IDLE, DRAIN always ends in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      case (state)
        IDLE:    if (go && !stop) state <= RUN;
        RUN:     if (stop) state <= DRAIN;
        DRAIN:   if (!redirect_valid && !req_v && cnt == 2'd0) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Program counter and in-flight read tracker.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc <= RESET_PC;
      req_v    <= 1'b0;
      req_pc   <= '0;
    end else if (redirect_valid) begin
      fetch_pc <= redirect_pc;
      req_v    <= 1'b0;
    end else if (issue) begin
      req_v    <= 1'b1;
      req_pc   <= fetch_pc;
      fetch_pc <= fetch_pc + 1'b1;
    end else begin
      req_v    <= 1'b0;
    end
  end

  fetch_skid_buf #(
    .DW(PC_W + WIDTH)
  ) u_buf (
    .clk  (clk),
    .rst_n(rst_n),
    .push (push),
    .din  ({req_pc, imem_ins}),
    .pop  (pop),
    .flush(redirect_valid),
    .full (buf_full),
    .cnt  (cnt),
    .head (head)
  );

  assign imem_pc   = fetch_pc;
  assign out_valid = (cnt != 2'd0);
  assign out_pc    = head[PC_W+WIDTH-1:WIDTH];
  assign out_ins   = head[WIDTH-1:0];
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: a registered-read memory model, directed scenarios
// and randomized stimulus checked against a queue-based reference model.
module tb_fetch_ctrl;

  localparam int WIDTH   = 32;
  localparam int PC_W    = 8;
  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_DRAIN = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             go;
  logic             stop;
  logic             redirect_valid;
  logic [PC_W-1:0]  redirect_pc;
  logic [PC_W-1:0]  imem_pc;
  logic [WIDTH-1:0] imem_ins;
  logic             out_valid;
  logic [WIDTH-1:0] out_ins;
  logic [PC_W-1:0]  out_pc;
  logic             out_ready;
  logic             busy;

  int total = 0;
  int bad   = 0;

  // Reference model: operating mode, next fetch address, reads in flight and
  // words waiting for decode, both as queues of word addresses.
  int              m_state;
  logic [PC_W-1:0] m_pc;
  logic [PC_W-1:0] m_infl[$];
  logic [PC_W-1:0] m_fifo[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // Memory: registered read port, mem[i] = 0x1000_0000 + i.
  always @(posedge clk) imem_ins <= mem_word(imem_pc);

  fetch_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .go            (go),
    .stop          (stop),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .imem_pc       (imem_pc),
    .imem_ins      (imem_ins),
    .out_valid     (out_valid),
    .out_ins       (out_ins),
    .out_pc        (out_pc),
    .out_ready     (out_ready),
    .busy          (busy)
  );

  function automatic logic [WIDTH-1:0] mem_word(input logic [PC_W-1:0] a);
    return 32'h1000_0000 + {24'h0, a};
  endfunction

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = M_IDLE;
    m_pc    = '0;
    m_infl.delete();
    m_fifo.delete();
  endtask

  task automatic model_step(input bit g, input bit s, input bit rv,
                            input logic [PC_W-1:0] rpc, input bit rdy);
    int n_f;
    int n_i;
    bit pop;
    bit iss;
    n_f = m_fifo.size();
    n_i = m_infl.size();
    pop = (n_f > 0) && rdy;
    iss = (m_state == M_RUN) && !s && !rv && ((n_f + n_i - int'(pop)) <= 1);
    if (pop) void'(m_fifo.pop_front());
    if (rv) begin
      m_infl.delete();
      m_fifo.delete();
      m_pc = rpc;
    end else begin
      while (m_infl.size() > 0) m_fifo.push_back(m_infl.pop_front());
      if (iss) begin
        m_infl.push_back(m_pc);
        m_pc = m_pc + 8'd1;
      end
    end
    case (m_state)
      M_IDLE:  if (g && !s) m_state = M_RUN;
      M_RUN:   if (s) m_state = M_DRAIN;
      default: if (!rv && n_i == 0 && n_f == 0) m_state = M_IDLE;
    endcase
  endtask

  task automatic compare_outputs();
    check("imem_pc", 64'(imem_pc), 64'(m_pc));
    check("out_valid", 64'(out_valid), 64'(m_fifo.size() != 0));
    if (m_fifo.size() != 0) begin
      check("out_pc", 64'(out_pc), 64'(m_fifo[0]));
      check("out_ins", 64'(out_ins), 64'(mem_word(m_fifo[0])));
    end
    check("busy", 64'(busy), 64'(m_state != M_IDLE));
    check("buf_cnt_le2", 64'(dut.u_buf.cnt <= 2'd2), 64'd1);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_imem_pc"}, 64'(imem_pc), 64'd0);
    check({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_out_ins"}, 64'(out_ins), 64'd0);
    check({tag, "_out_pc"}, 64'(out_pc), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
  endtask

  // ---------------- driver ----------------
  // Called at a falling edge: drive, advance model, cross one rising edge,
  // compare at the next falling edge.
  task automatic cycle(input bit g, input bit s, input bit rv,
                       input logic [PC_W-1:0] rpc, input bit rdy);
    go             = g;
    stop           = s;
    redirect_valid = rv;
    redirect_pc    = rpc;
    out_ready      = rdy;
    model_step(g, s, rv, rpc, rdy);
    @(posedge clk);
    @(negedge clk);
    compare_outputs();
  endtask

  // ---------------- main ----------------
  initial begin
    int waited;
    rst_n = 1'b0;
    go = 0; stop = 0; redirect_valid = 0; redirect_pc = '0; out_ready = 0;
    model_reset();
    #1;
    check_reset_values("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    compare_outputs();

    // Startup: go in cycle 0, first word visible in cycle 3.
    cycle(1, 0, 0, 8'h00, 1);
    cycle(1, 0, 0, 8'h00, 1);
    check("start_no_valid_c2", 64'(out_valid), 64'd0);
    cycle(1, 0, 0, 8'h00, 1);
    check("start_valid_c3", 64'(out_valid), 64'd1);
    check("start_pc_c3", 64'(out_pc), 64'h00);
    check("start_ins_c3", 64'(out_ins), 64'h1000_0000);
    repeat (4) cycle(0, 0, 0, 8'h00, 1);

    // Backpressure: 5 stalled cycles then release.
    repeat (5) cycle(0, 0, 0, 8'h00, 0);
    repeat (4) cycle(0, 0, 0, 8'h00, 1);

    // Redirect to 0x40.
    cycle(0, 0, 1, 8'h40, 1);
    check("redir_imem_pc", 64'(imem_pc), 64'h40);
    check("redir_gap1", 64'(out_valid), 64'd0);
    cycle(0, 0, 0, 8'h00, 1);
    check("redir_gap2", 64'(out_valid), 64'd0);
    cycle(0, 0, 0, 8'h00, 1);
    check("redir_pc", 64'(out_pc), 64'h40);
    check("redir_ins", 64'(out_ins), 64'h1000_0040);
    repeat (3) cycle(0, 0, 0, 8'h00, 1);

    // Wrap: FE, FF, 00, 01.
    cycle(0, 0, 1, 8'hFE, 1);
    cycle(0, 0, 0, 8'h00, 1);
    for (int i = 0; i < 4; i++) begin
      cycle(0, 0, 0, 8'h00, 1);
      check("wrap_pc", 64'(out_pc), 64'((8'hFE + i) & 8'hFF));
    end

    // Stop and drain, then resume from the retained pc.
    cycle(0, 1, 0, 8'h00, 1);
    waited = 0;
    while (busy && waited < 6) begin
      cycle(0, 1, 0, 8'h00, 1);
      waited++;
    end
    check("stop_idle_in_3", 64'(waited <= 3), 64'd1);
    cycle(0, 0, 0, 8'h00, 1);
    repeat (6) cycle(1, 0, 0, 8'h00, 1);

    // Randomized traffic.
    for (int i = 0; i < 500; i++) begin
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0,
            $urandom_range(0, 19) == 0, 8'($urandom_range(0, 255)),
            $urandom_range(0, 3) != 0);
    end

    // Async reset with a full buffer.
    repeat (3) cycle(1, 0, 0, 8'h00, 1);
    repeat (6) cycle(1, 0, 0, 8'h00, 0);
    check("pre_reset_full", 64'(m_fifo.size()), 64'd2);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_values("async_rst");
    go = 0; stop = 0; redirect_valid = 0; out_ready = 0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    compare_outputs();
    repeat (8) cycle(1, 0, 0, 8'h00, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
